// File: rtl/mm_pkg.sv
// Shared constants and helpers for the matrix-multiply datapath (PE chain, feeder, drain).
package mm_pkg;

    localparam int unsigned D_W_ACC = 64;
    localparam int unsigned N       = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned x = 1; x < value; x = x << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module mm_sync_fifo import mm_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   fill_o
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             push_ok, pop_ok;

    assign full_o  = (fill_q == (AW+1)'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    // Forced to zero when empty so the output word is defined out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            fill_d = fill_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mm_col_drain.sv
// Buffers the non-stallable result chain of one PE column and re-emits it as a
// valid/ready stream with a last flag every N words.
module mm_col_drain import mm_pkg::*; #(
    parameter int unsigned D_W_ACC    = mm_pkg::D_W_ACC,
    parameter int unsigned N          = mm_pkg::N,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [D_W_ACC-1:0]            in_data,
    input  logic                          in_valid,
    output logic [D_W_ACC-1:0]            m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [clog2(FIFO_DEPTH):0]    fill,
    output logic                          overflow
);

    localparam int unsigned CntW = (N > 1) ? clog2(N) : 1;

    logic            full, empty, pop, drop;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overflow_q, overflow_d;

    mm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (D_W_ACC)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (m_tdata),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill)
    );

    assign m_tvalid = ~empty;
    assign pop      = m_tvalid & m_tready;
    assign drop     = in_valid & full & ~pop;
    assign m_tlast  = m_tvalid & (cnt_q == CntW'(N - 1));
    assign overflow = overflow_q;

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q | drop;
        if (pop) begin
            cnt_d = (cnt_q == CntW'(N - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mm_col_drain.sv
// Scoreboard bench for mm_col_drain: stimulus queues expected words, a negedge monitor checks pops.
module tb_mm_col_drain;

    localparam int unsigned W  = 64;
    localparam int unsigned NB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [4:0]    fill;
    logic          overflow;

    int            total = 0;
    int            bad = 0;
    int            pop_idx = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  e;

    mm_col_drain #(
        .D_W_ACC    (64),
        .N          (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .fill     (fill),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word must be the oldest queued word.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tlast && !m_tvalid) begin
                chk("tlast_without_valid", 64'(m_tlast), 64'd0);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", m_tdata, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", m_tdata, e);
                    chk("pop_tlast", 64'(m_tlast), 64'((pop_idx % NB) == NB - 1));
                    pop_idx++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; acc says whether the word is expected to be stored.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic rdy, input logic acc);
        in_valid = iv;
        in_data  = d;
        m_tready = rdy;
        if (iv && acc) exp_q.push_back(d);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        pop_idx = 0;
        tick();
        rst = 1'b0;
    endtask

    logic [W-1:0] ref_sum;

    initial begin
        // Power-up reset
        #2;
        chk("init_fill", 64'(fill), 64'd0);
        chk("init_tvalid", 64'(m_tvalid), 64'd0);
        chk("init_tdata", m_tdata, 64'd0);
        chk("init_overflow", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;

        // 1. Mid-burst async reset: cnt=3 after 3 pops, then 5 words parked.
        for (int i = 0; i < 3; i++) step(1'b1, 64'(50 + i), 1'b1, 1'b1);
        drain();
        for (int i = 0; i < 5; i++) step(1'b1, 64'(60 + i), 1'b0, 1'b1);
        chk("pre_rst_fill", 64'(fill), 64'd5);
        do_reset();

        // 2. Streaming 1..16, tlast only on 16 (cnt restarted by reset).
        chk("empty_tvalid", 64'(m_tvalid), 64'd0);
        step(1'b1, 64'd1, 1'b1, 1'b1);
        chk("latency_tvalid", 64'(m_tvalid), 64'd1);
        chk("latency_tdata", m_tdata, 64'd1);
        for (int i = 2; i <= 16; i++) step(1'b1, 64'(i), 1'b1, 1'b1);
        chk("stream_fill", 64'(fill), 64'd1);
        drain();
        chk("stream_overflow", 64'(overflow), 64'd0);

        // 4. Fill to 16 under backpressure, then simultaneous push/pop while full.
        for (int i = 0; i < 16; i++) step(1'b1, 64'(101 + i), 1'b0, 1'b1);
        chk("bp_fill", 64'(fill), 64'd16);
        chk("bp_tvalid", 64'(m_tvalid), 64'd1);
        chk("bp_tdata_held", m_tdata, 64'd101);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_tdata_still", m_tdata, 64'd101);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 64'(201 + i), 1'b1, 1'b1);
            chk("full_pushpop_fill", 64'(fill), 64'd16);
        end
        chk("full_pushpop_overflow", 64'(overflow), 64'd0);

        // 3. Push into a full FIFO with no pop: dropped, overflow sticks.
        step(1'b1, 64'd999, 1'b0, 1'b0);
        chk("ovf_fill", 64'(fill), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", m_tdata, 64'd111);
        drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // 5. Three bursts with random ready; reset realigns the burst counter.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 64'(301 + i), ($urandom % 2 == 0) || (exp_q.size() >= 12), 1'b1);
        end
        drain();
        chk("wrap_pops", 64'(pop_idx), 64'd48);
        chk("wrap_overflow", 64'(overflow), 64'd0);

        // 6. Column of dot products: A[r][k] = r+k+1, B[k] = 2k+1.
        for (int r = 0; r < 16; r++) begin
            ref_sum = '0;
            for (int k = 0; k < 16; k++) ref_sum += 64'((r + k + 1) * (2 * k + 1));
            step(1'b1, ref_sum, 1'b1, 1'b1);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        drain();
        chk("dot_pops", 64'(pop_idx), 64'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
